mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter that shares one single-ported unified memory between the instruction-fetch path and the load/store path of the core. It accepts a fetch request and a data request, granted from `memRead`/`memWrite` of the decoded instruction, and serialises them onto the memory port, one outstanding transaction at a time. It returns per-requester completion pulses and a stall signal for the pipeline.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits. Used only with `ARB_FAIR_EN`; legal range 1..15.
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_if_req`  in  1  fetch request; held until `o_if_valid`
- `i_if_addr`  in  32  fetch word address
- `o_if_valid`  out  1  one-cycle pulse: `o_if_rdata` valid, fetch complete
- `o_if_rdata`  out  32  fetched instruction
- `i_d_read`  in  1  load request; held until `o_d_done`
- `i_d_write`  in  1  store request; held until `o_d_done`
- `i_d_addr`  in  32  data address
- `i_d_wdata`  in  32  store data
- `i_d_mask`  in  4  store byte enables
- `o_d_done`  out  1  one-cycle pulse: data access complete
- `o_d_rdata`  out  32  load data, valid with `o_d_done`
- `o_mem_req`  out  1  memory request
- `o_mem_wen`  out  1  1 = write, 0 = read
- `o_mem_addr`  out  32  memory address
- `o_mem_wdata`  out  32  memory write data
- `o_mem_mask`  out  4  byte enables; forced to 4'hF on reads
- `i_mem_ready`  in  1  memory accepts request this cycle
- `i_mem_rvalid`  in  1  read data valid
- `i_mem_rdata`  in  32  read data
- `o_stall`  out  1  pipeline stall

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Register `owner` is 0 = fetch, 1 = data.
- IDLE:
  - If any request is present, arbitrate.
  - Latch the winner's addr, wdata, mask and wen into the port registers.
  - Set `owner` and go to REQ.
- Arbitration: data beats fetch, because data belongs to the older instruction. If `i_d_read` and `i_d_write` are both high, treat it as a write; the requester must not drive both.
- REQ:
  - `o_mem_req` = 1 with the latched fields.
  - When `i_mem_ready` = 1 on a write, go to RESP.
  - When `i_mem_ready` = 1 on a read, go to WAIT.
  - Otherwise stay in REQ with the fields held stable.
- WAIT: on `i_mem_rvalid`, register `i_mem_rdata` into the owner's rdata output and go to RESP. Any `i_mem_rvalid` seen outside WAIT is ignored.
- RESP:
  - Pulse `o_if_valid` or `o_d_done` for one cycle, per `owner`.
  - Go to IDLE. No arbitration happens in RESP.
- Write completion: `o_d_done` pulses and `o_d_rdata` is unchanged.
- `o_if_rdata` and `o_d_rdata` hold their last value until overwritten.
- `o_stall` = (`i_if_req` & ~`o_if_valid`) | ((`i_d_read` | `i_d_write`) & ~`o_d_done`). This is combinational.
- A request dropped by the requester before completion is illegal. The arbiter completes the transaction regardless.

## Timing
- Reset (async, immediate):
  - State returns to IDLE and the transaction is abandoned.
  - All outputs are 0: `o_mem_req`, `o_mem_wen`, `o_mem_addr`, `o_mem_wdata`, `o_mem_mask`, `o_if_valid`, `o_if_rdata`, `o_d_done`, `o_d_rdata`.
  - The starvation counter is 0.
- Read with ready on the first REQ cycle and rvalid the following cycle:
  - request seen in IDLE at cycle 0
  - REQ at cycle 1
  - WAIT at cycle 2, rvalid arrives
  - RESP pulse at cycle 3
  - IDLE at cycle 4
- Write: IDLE at 0, REQ+ready at 1, RESP pulse at 2. Minimum 3 cycles.
- `i_mem_rvalid` in the same cycle as acceptance is not supported. Memory returns read data no earlier than one cycle after acceptance.
- A new transaction is at the earliest one cycle after the RESP pulse. Back-to-back requesters therefore see a 4-cycle read period and a 3-cycle write period.
- Each `i_mem_ready` stall cycle adds one cycle. Each cycle spent waiting for rvalid adds one cycle.

## Configuration
- `ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each data grant made while `i_if_req` = 1. It saturates at `STARVE_LIMIT`.
  - The counter clears on any fetch grant.
  - When the counter equals `STARVE_LIMIT` and both requesters are present, fetch wins.
- `ARB_FAIR_EN` undefined: strict data priority; the counter logic is absent.

## Test plan
- Reset while in WAIT with a pending read → all outputs 0 immediately; later stray `i_mem_rvalid` = 1 produces no pulse.
- Fetch only, addr 0x0000_0040, ready immediately, rvalid one cycle later with 0x0050_0093 → `o_if_valid` pulse at cycle 3 with `o_if_rdata` = 0x0050_0093; `o_stall` low from cycle 4.
- Store to 0x0000_1000, wdata 0xDEAD_BEEF, mask 4'b0011, `i_mem_ready` low for 2 cycles → `o_mem_*` held stable for 3 REQ cycles, `o_mem_wen` = 1, `o_d_done` pulse at cycle 4.
- Fetch and load asserted together in IDLE → memory sees the load address first; `o_d_done` pulses, then the fetch is granted in the next IDLE.
- Load with `i_mem_rdata` = 0x1234_5678 → `o_d_rdata` = 0x1234_5678 on `o_d_done`; `o_mem_mask` = 4'hF during REQ.
- `ARB_FAIR_EN`, `STARVE_LIMIT` = 4, fetch and data held continuously → 4 data grants, then 1 fetch grant, repeating. Without the macro, no fetch grant while data stays asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and load/store.
// Define ARB_FAIR_EN to let a waiting fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_read,
  input  logic        i_d_write,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_done,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic d_any;
  logic any_req;
  logic grant_d;
  logic arb_en;

  assign d_any   = i_d_read | i_d_write;
  assign any_req = d_any | i_if_req;
  assign arb_en  = (state_q == IDLE) & any_req;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_chk
    $error("STARVE_LIMIT must be in 1..15");
  end

`ifdef ARB_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = i_if_req & (starve_q == LIMIT);
  assign grant_d = d_any & ~starved;

  // Count data grants that overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (arb_en) begin
      if (grant_d) begin
        if (i_if_req && starve_q != LIMIT) begin
          starve_d = starve_q + 4'd1;
        end
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_d = d_any;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          state_d = wen_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (arb_en) begin
      owner_d = grant_d;
      if (grant_d) begin
        wen_d   = i_d_write;
        addr_d  = i_d_addr;
        wdata_d = i_d_wdata;
        mask_d  = i_d_write ? i_d_mask : 4'hF;
      end else begin
        wen_d   = 1'b0;
        addr_d  = i_if_addr;
        wdata_d = '0;
        mask_d  = 4'hF;
      end
    end
    // Read data is only taken while a read is actually outstanding.
    if (state_q == WAIT && i_mem_rvalid) begin
      if (owner_q) begin
        d_rdata_d = i_mem_rdata;
      end else begin
        if_rdata_d = i_mem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q    <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    o_mem_req  = (state_q == REQ);
    o_if_valid = (state_q == RESP) & ~owner_q;
    o_d_done   = (state_q == RESP) & owner_q;
  end

  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;

  assign o_stall = (i_if_req & ~o_if_valid) | (d_any & ~o_d_done);

endmodule
